alu_writeback: RTL and testbench

ALU_WRITEBACK -- requirements
Module: alu_writeback

---
 rtl/mcpu_pkg.sv | 16 +
 rtl/alu_status_reg.sv | 33 +++
 rtl/alu_writeback.sv | 105 ++++++++++
 tb/tb_alu_writeback.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/mcpu_pkg.sv
// Shared definitions for the ALU writeback slice: FSM states, STATUS bit positions, destination codes.
package mcpu_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } wb_state_t;

  localparam int ST_C  = 0;
  localparam int ST_DC = 1;
  localparam int ST_Z  = 2;

  localparam logic DEST_W  = 1'b0;
  localparam logic DEST_RF = 1'b1;

endpackage

// File: rtl/alu_status_reg.sv
// STATUS {Z, DC, C} register with per-bit ALU mask and explicit core write merge.
// Latency 1 cycle; no backpressure (updates whenever upd or st_we is asserted).
module alu_status_reg
  import mcpu_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       upd,
  input  logic [2:0] flags,
  input  logic [2:0] fmask,
  input  logic       st_we,
  input  logic [2:0] st_wdata,
  output logic [2:0] status
);

  logic [2:0] base;
  logic [2:0] nxt;

  // Masked ALU flags win over an explicit write landing in the same cycle.
  always_comb begin
    base = st_we ? st_wdata : status;
    nxt  = upd ? ((fmask & flags) | (~fmask & base)) : base;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      status <= 3'b000;
    end else begin
      status <= nxt;
    end
  end

endmodule

// File: rtl/alu_writeback.sv
// ALU result writeback to W or register file; optional skip-on-zero under ALU_WB_SKIP_EN.
// Latency 1 cycle to W/STATUS/rf_we; in_ready low while a register-file write waits for rf_ready.
module alu_writeback
  import mcpu_pkg::*;
#(
  parameter int DW = 8,
  parameter int AW = 7
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_sum,
  input  logic          in_c,
  input  logic          in_dc,
  input  logic          in_dest,
  input  logic [AW-1:0] in_faddr,
  input  logic [2:0]    in_fmask,
  input  logic          in_skipz,
  input  logic          st_we,
  input  logic [2:0]    st_wdata,
  output logic [DW-1:0] w_out,
  output logic [2:0]    status_out,
  output logic          rf_we,
  output logic [AW-1:0] rf_addr,
  output logic [DW-1:0] rf_wdata,
  input  logic          rf_ready,
  output logic          skip
);

  wb_state_t  state;
  logic       accept;
  logic       zero;
  logic [2:0] flags;

  assign in_ready = (state == IDLE);
  assign accept   = in_valid && in_ready;
  assign zero     = (in_sum == '0);

  always_comb begin
    flags        = 3'b000;
    flags[ST_Z]  = zero;
    flags[ST_DC] = in_dc;
    flags[ST_C]  = in_c;
  end

  alu_status_reg u_status (
    .clk      (clk),
    .rst      (rst),
    .upd      (accept),
    .flags    (flags),
    .fmask    (in_fmask),
    .st_we    (st_we),
    .st_wdata (st_wdata),
    .status   (status_out)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      w_out    <= '0;
      rf_we    <= 1'b0;
      rf_addr  <= '0;
      rf_wdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            if (in_dest == DEST_W) begin
              w_out <= in_sum;
            end else begin
              rf_addr  <= in_faddr;
              rf_wdata <= in_sum;
              rf_we    <= 1'b1;
              state    <= WRITE;
            end
          end
        end
        WRITE: begin
          // Address/data hold until the register file takes the write.
          if (rf_ready) begin
            rf_we <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ALU_WB_SKIP_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      skip <= 1'b0;
    end else begin
      skip <= accept && in_skipz && zero;
    end
  end
`else
  logic unused_skipz;
  assign unused_skipz = in_skipz;
  assign skip = 1'b0;
`endif

endmodule

// File: tb/tb_alu_writeback.sv
// Randomized and directed bench for alu_writeback against a behavioural model.
module tb_alu_writeback;

  localparam int DW = 8;
  localparam int AW = 7;
`ifdef ALU_WB_SKIP_EN
  localparam bit SKIP_EN = 1'b1;
`else
  localparam bit SKIP_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_sum = '0;
  logic          in_c = 1'b0;
  logic          in_dc = 1'b0;
  logic          in_dest = 1'b0;
  logic [AW-1:0] in_faddr = '0;
  logic [2:0]    in_fmask = 3'b000;
  logic          in_skipz = 1'b0;
  logic          st_we = 1'b0;
  logic [2:0]    st_wdata = 3'b000;
  logic [DW-1:0] w_out;
  logic [2:0]    status_out;
  logic          rf_we;
  logic [AW-1:0] rf_addr;
  logic [DW-1:0] rf_wdata;
  logic          rf_ready = 1'b0;
  logic          skip;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_writeback #(.DW(DW), .AW(AW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_sum(in_sum), .in_c(in_c), .in_dc(in_dc), .in_dest(in_dest),
    .in_faddr(in_faddr), .in_fmask(in_fmask), .in_skipz(in_skipz),
    .st_we(st_we), .st_wdata(st_wdata), .w_out(w_out), .status_out(status_out),
    .rf_we(rf_we), .rf_addr(rf_addr), .rf_wdata(rf_wdata), .rf_ready(rf_ready),
    .skip(skip)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a pending-write flag plus the architectural registers.
  bit            model_ok = 1'b0;
  bit            m_busy;
  logic [DW-1:0] m_w;
  logic [2:0]    m_st;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data;
  bit            m_skip;

  always @(posedge clk) begin
    bit acc;
    bit z;
    logic [2:0] alu_flags;
    logic [2:0] nst;
    if (rst) begin
      model_ok = 1'b1;
      m_busy = 1'b0; m_w = '0; m_st = 3'b000; m_addr = '0; m_data = '0; m_skip = 1'b0;
    end else begin
      acc = in_valid && !m_busy;
      z = (in_sum == 0);
      alu_flags = {z, in_dc, in_c};
      nst = st_we ? st_wdata : m_st;
      if (acc)
        for (int i = 0; i < 3; i++)
          if (in_fmask[i]) nst[i] = alu_flags[i];
      m_st = nst;
      m_skip = SKIP_EN && acc && in_skipz && z;
      if (m_busy) begin
        if (rf_ready) m_busy = 1'b0;
      end else if (acc) begin
        if (in_dest) begin
          m_busy = 1'b1; m_addr = in_faddr; m_data = in_sum;
        end else begin
          m_w = in_sum;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (model_ok) begin
      chk("cmp_in_ready", in_ready, !m_busy);
      chk("cmp_w_out", w_out, m_w);
      chk("cmp_status", status_out, m_st);
      chk("cmp_rf_we", rf_we, m_busy);
      chk("cmp_rf_addr", rf_addr, m_addr);
      chk("cmp_rf_wdata", rf_wdata, m_data);
      chk("cmp_skip", skip, m_skip);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    in_valid = 0; in_sum = '0; in_c = 0; in_dc = 0; in_dest = 0; in_faddr = '0;
    in_fmask = 3'b000; in_skipz = 0; st_we = 0; st_wdata = 3'b000; rf_ready = 0;
  endtask

  task automatic acc_in(input logic [DW-1:0] s, input logic c, input logic dc,
                        input logic d, input logic [AW-1:0] fa, input logic [2:0] fm,
                        input logic sz);
    in_valid = 1; in_sum = s; in_c = c; in_dc = dc; in_dest = d; in_faddr = fa;
    in_fmask = fm; in_skipz = sz;
  endtask

  initial begin
    idle_in();
    rst = 1; cyc(); cyc();
    rst = 0;
    chk("rst_w_out", w_out, 8'h00);
    chk("rst_status", status_out, 3'b000);
    chk("rst_rf_we", rf_we, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_skip", skip, 1'b0);

    // Zero sum with all flags enabled.
    acc_in(8'h00, 1, 1, 0, '0, 3'b111, 0); cyc(); idle_in();
    chk("zero_w_out", w_out, 8'h00);
    chk("zero_status", status_out, 3'b111);

    // Back-to-back W writes.
    for (int i = 1; i <= 4; i++) begin
      acc_in(i[7:0], 0, 0, 0, '0, 3'b000, 0);
      cyc();
      chk("b2b_w_out", w_out, i);
      chk("b2b_in_ready", in_ready, 1'b1);
    end
    idle_in();

    // ALU Z merged with explicit STATUS write.
    acc_in(8'h01, 0, 0, 0, '0, 3'b100, 0); st_we = 1; st_wdata = 3'b011;
    cyc(); idle_in();
    chk("merge_status", status_out, 3'b011);
    chk("merge_w_out", w_out, 8'h01);

    // rf_ready with nothing pending does nothing.
    rf_ready = 1; cyc(); rf_ready = 0;
    chk("idle_rdy_rf_we", rf_we, 1'b0);

    // Register-file write stalled three cycles; inputs offered meanwhile must be ignored.
    acc_in(8'h5A, 0, 0, 1, 7'h20, 3'b000, 0); cyc();
    acc_in(8'hFF, 1, 1, 0, '0, 3'b111, 0);
    for (int i = 0; i < 3; i++) begin
      chk("stall_rf_we", rf_we, 1'b1);
      chk("stall_rf_addr", rf_addr, 7'h20);
      chk("stall_rf_wdata", rf_wdata, 8'h5A);
      chk("stall_in_ready", in_ready, 1'b0);
      cyc();
    end
    idle_in(); rf_ready = 1;
    chk("stall_last_rf_we", rf_we, 1'b1);
    cyc(); rf_ready = 0;
    chk("done_rf_we", rf_we, 1'b0);
    chk("done_in_ready", in_ready, 1'b1);
    chk("done_w_out", w_out, 8'h01);
    chk("done_status", status_out, 3'b011);

    // Reset aborts a pending write.
    acc_in(8'h33, 0, 0, 1, 7'h11, 3'b000, 0); cyc(); idle_in();
    chk("abort_pre_rf_we", rf_we, 1'b1);
    rst = 1; cyc(); rst = 0;
    chk("abort_rf_we", rf_we, 1'b0);
    chk("abort_in_ready", in_ready, 1'b1);
    chk("abort_rf_addr", rf_addr, 7'h00);
    chk("abort_rf_wdata", rf_wdata, 8'h00);
    chk("abort_w_out", w_out, 8'h00);
    chk("abort_status", status_out, 3'b000);

    // Skip-on-zero, independent of fmask.
    acc_in(8'h00, 0, 0, 0, '0, 3'b000, 1); cyc(); idle_in();
    chk("skip_zero", skip, SKIP_EN);
    cyc();
    chk("skip_one_cycle", skip, 1'b0);
    acc_in(8'h01, 0, 0, 0, '0, 3'b111, 1); cyc(); idle_in();
    chk("skip_nonzero", skip, 1'b0);

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      rst      = ($urandom_range(0, 99) == 0);
      in_valid = ($urandom_range(0, 9) < 7);
      in_sum   = ($urandom_range(0, 3) == 0) ? 8'h00 : DW'($urandom);
      in_c     = $urandom_range(0, 1);
      in_dc    = $urandom_range(0, 1);
      in_dest  = $urandom_range(0, 1);
      in_faddr = AW'($urandom);
      in_fmask = 3'($urandom);
      in_skipz = $urandom_range(0, 1);
      st_we    = ($urandom_range(0, 4) == 0);
      st_wdata = 3'($urandom);
      rf_ready = $urandom_range(0, 1);
      cyc();
    end
    rst = 0; idle_in();
    cyc(); cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
